// File: rtl/msg_serialiser_pkg.sv
// Shared types and constants for the message serialiser.
package msg_serialiser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_HEADER_WORD = 8'hA5;

  // Width needed to hold a word count of 0..max_words inclusive.
  function automatic int unsigned len_width(input int unsigned max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/msg_serialiser_if.sv
// Message-in / word-out handshake bundle for the message serialiser.
interface msg_serialiser_if
  import msg_serialiser_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned MAX_WORDS = 4,
  parameter int unsigned LEN_W     = len_width(MAX_WORDS)
) ();

  logic [WORD_SIZE*MAX_WORDS-1:0] in_data;
  logic [LEN_W-1:0]               in_len;
  logic                           in_valid;
  logic                           in_ready;
  logic [WORD_SIZE-1:0]           out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic                           out_last;

  // Environment side: offers messages, consumes words.
  modport master (
    output in_data, in_len, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  // Serialiser side.
  modport slave (
    input  in_data, in_len, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/msg_serialiser.sv
// Captures a multi-word message and emits it one word per transfer,
// with optional header word and last-word marker.
module msg_serialiser
  import msg_serialiser_pkg::*;
#(
  parameter int unsigned          WORD_SIZE   = 8,
  parameter int unsigned          MAX_WORDS   = 4,
  parameter bit                   MSW_FIRST   = 1'b0,
  parameter bit                   HEADER_EN   = 1'b0,
  parameter logic [WORD_SIZE-1:0] HEADER_WORD = WORD_SIZE'(DEFAULT_HEADER_WORD)
) (
  input  logic            clk,
  input  logic            reset,
  msg_serialiser_if.slave bus,
  output logic            busy,
  output logic            len_err
);

  localparam int unsigned      LEN_W   = len_width(MAX_WORDS);
  localparam int unsigned      BUS_W   = WORD_SIZE * MAX_WORDS;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  state_t               state, state_n;
  logic [BUS_W-1:0]     cap_q, cap_n;
  logic [LEN_W-1:0]     len_q, len_n;
  logic [LEN_W-1:0]     cnt_q, cnt_n;
  logic [WORD_SIZE-1:0] data_q, data_n;
  logic                 valid_q, valid_n;
  logic                 last_q, last_n;
  logic                 err_q, err_n;
  logic                 ready, accept, xfer, in_len_bad;
  logic [LEN_W-1:0]     eff_len;

  // Word presented at send position pos of a message of length len.
  function automatic logic [WORD_SIZE-1:0] pick_word(
    input logic [BUS_W-1:0] msg,
    input logic [LEN_W-1:0] len,
    input logic [LEN_W-1:0] pos
  );
    logic [LEN_W-1:0]     idx;
    logic [WORD_SIZE-1:0] word;
    idx  = MSW_FIRST ? (len - pos - ONE) : pos;
    word = '0;
    for (int unsigned i = 0; i < MAX_WORDS; i++) begin
      if (LEN_W'(i) == idx) word = msg[i*WORD_SIZE +: WORD_SIZE];
    end
    return word;
  endfunction

  assign xfer       = valid_q && bus.out_ready;
  assign ready      = (state == IDLE) || (xfer && last_q);
  assign accept     = bus.in_valid && ready;
  assign in_len_bad = (bus.in_len == '0) || (bus.in_len > MAX_LEN);
  assign eff_len    = (bus.in_len > MAX_LEN) ? MAX_LEN : bus.in_len;

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign busy          = (state != IDLE);
  assign len_err       = err_q;

  // Next state and next registered outputs.
  always_comb begin
    state_n = state;
    cap_n   = cap_q;
    len_n   = len_q;
    cnt_n   = cnt_q;
    data_n  = data_q;
    valid_n = valid_q;
    last_n  = last_q;
    err_n   = 1'b0;

    case (state)
      IDLE: ;
      HDR: begin
        if (xfer) begin
          if (len_q == '0) begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
          end else begin
            state_n = DATA;
            cnt_n   = '0;
            data_n  = pick_word(cap_q, len_q, '0);
            last_n  = (len_q == ONE);
          end
        end
      end
      DATA: begin
        if (xfer) begin
          if (last_q) begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
          end else begin
            cnt_n  = cnt_q + ONE;
            data_n = pick_word(cap_q, len_q, cnt_q + ONE);
            last_n = ((cnt_q + ONE) == (len_q - ONE));
          end
        end
      end
      DROP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Acceptance overrides the completing message so the next one starts
    // without a bubble; the first word comes straight from in_data because
    // the capture register only loads on this same edge.
    if (accept) begin
      cap_n = bus.in_data;
      len_n = eff_len;
      cnt_n = '0;
      err_n = in_len_bad;
      if (HEADER_EN) begin
        state_n = HDR;
        valid_n = 1'b1;
        data_n  = HEADER_WORD;
        last_n  = (eff_len == '0);
      end else if (eff_len == '0) begin
        state_n = DROP;
        valid_n = 1'b0;
        last_n  = 1'b0;
      end else begin
        state_n = DATA;
        valid_n = 1'b1;
        data_n  = pick_word(bus.in_data, eff_len, '0);
        last_n  = (eff_len == ONE);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Capture, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cap_q   <= cap_n;
      len_q   <= len_n;
      cnt_q   <= cnt_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      last_q  <= last_n;
      err_q   <= err_n;
    end
  end

endmodule

// File: tb/tb_msg_serialiser.sv
// Bench for msg_serialiser: lane 0 uses default parameters, lane 1 uses
// MSW_FIRST=1 with header enabled. Each lane has a source driver and a
// queue-based word model checked every cycle.
module tb_msg_serialiser;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  len;
  } msg_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       l;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: 1,0,0,1 pattern
  bit   zero_after = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam bit SWAP = (g == 1);
    localparam bit HEN  = (g == 1);

    msg_serialiser_if #(.WORD_SIZE(8), .MAX_WORDS(4)) bus ();
    logic busy, len_err;

    msg_t msgq[$];
    exp_t q[$];
    rec_t log[$];
    bit   acc_seen, drop_now, exp_err;
    int   busy_cycles, err_pulses, pc;

    msg_serialiser #(
      .WORD_SIZE  (8),
      .MAX_WORDS  (4),
      .MSW_FIRST  (SWAP),
      .HEADER_EN  (HEN),
      .HEADER_WORD(8'hA5)
    ) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus.slave),
      .busy   (busy),
      .len_err(len_err)
    );

    // Source and sink driver, updated just after each rising edge.
    initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_len    = '0;
      bus.out_ready = 1'b0;
      pc = 0;
      forever begin
        @(posedge clk);
        #1;
        if (acc_seen) begin
          void'(msgq.pop_front());
          bus.in_valid = 1'b0;
          if (zero_after) bus.in_data = '0;
          else            bus.in_data = $urandom;
        end
        if (!bus.in_valid && msgq.size() != 0 && !reset &&
            !(rdy_mode == 1 && $urandom_range(0, 3) == 0)) begin
          bus.in_valid = 1'b1;
          bus.in_data  = msgq[0].data;
          bus.in_len   = msgq[0].len;
        end
        case (rdy_mode)
          0:       bus.out_ready = 1'b1;
          1:       bus.out_ready = 1'($urandom_range(0, 1));
          default: bus.out_ready = ((pc % 4) == 0) || ((pc % 4) == 3);
        endcase
        pc++;
      end
    end

    // Behavioural model: expected word queue built at acceptance.
    always @(negedge clk) begin
      logic exp_busy, exp_ready;
      int   eff, idx;
      exp_t e;
      rec_t r;
      if (reset) begin
        chk($sformatf("L%0d rst out_valid", g), bus.out_valid, 0);
        chk($sformatf("L%0d rst out_data", g), bus.out_data, 0);
        chk($sformatf("L%0d rst out_last", g), bus.out_last, 0);
        chk($sformatf("L%0d rst busy", g), busy, 0);
        chk($sformatf("L%0d rst len_err", g), len_err, 0);
        q.delete();
        drop_now = 1'b0;
        exp_err  = 1'b0;
        acc_seen = 1'b0;
      end else begin
        exp_busy  = (q.size() != 0) || drop_now;
        exp_ready = !exp_busy || (q.size() != 0 && bus.out_ready && q[0].l);
        chk($sformatf("L%0d busy", g), busy, exp_busy);
        chk($sformatf("L%0d in_ready", g), bus.in_ready, exp_ready);
        chk($sformatf("L%0d out_valid", g), bus.out_valid, q.size() != 0);
        chk($sformatf("L%0d len_err", g), len_err, exp_err);
        if (busy) busy_cycles++;
        if (len_err) err_pulses++;
        if (q.size() != 0) begin
          chk($sformatf("L%0d out_data", g), bus.out_data, q[0].d);
          chk($sformatf("L%0d out_last", g), bus.out_last, q[0].l);
          if (bus.out_ready) begin
            r.cyc = cyc;
            r.d   = bus.out_data;
            r.l   = bus.out_last;
            log.push_back(r);
            void'(q.pop_front());
          end
        end
        drop_now = 1'b0;
        exp_err  = 1'b0;
        acc_seen = bus.in_valid && bus.in_ready;
        if (bus.in_valid && exp_ready) begin
          eff     = (bus.in_len > 3'd4) ? 4 : int'(bus.in_len);
          exp_err = (bus.in_len == 3'd0) || (bus.in_len > 3'd4);
          if (HEN) begin
            e.d = 8'hA5;
            e.l = (eff == 0);
            q.push_back(e);
          end
          for (int k = 0; k < eff; k++) begin
            idx = SWAP ? (eff - 1 - k) : k;
            e.d = bus.in_data[idx*8 +: 8];
            e.l = (k == eff - 1);
            q.push_back(e);
          end
          if (!HEN && eff == 0) drop_now = 1'b1;
        end
      end
    end
  end

  function automatic bit all_idle();
    return lane[0].msgq.size() == 0 && !lane[0].bus.in_valid && lane[0].q.size() == 0 &&
           !lane[0].drop_now && !lane[0].busy &&
           lane[1].msgq.size() == 0 && !lane[1].bus.in_valid && lane[1].q.size() == 0 &&
           !lane[1].drop_now && !lane[1].busy;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!all_idle() && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk({tag, " idle timeout"}, n >= 3000, 0);
  endtask

  task automatic clear_logs();
    lane[0].log.delete();
    lane[1].log.delete();
    lane[0].busy_cycles = 0;
    lane[1].busy_cycles = 0;
    lane[0].err_pulses  = 0;
    lane[1].err_pulses  = 0;
  endtask

  task automatic check_log(input int ln, input string tag, input logic [7:0] ed [8],
                           input int n, input logic [7:0] lmask, input bit consec);
    rec_t lg[$];
    if (ln == 0) lg = lane[0].log;
    else         lg = lane[1].log;
    chk({tag, " count"}, lg.size(), n);
    for (int i = 0; i < n && i < lg.size(); i++) begin
      chk($sformatf("%s w%0d data", tag, i), lg[i].d, ed[i]);
      chk($sformatf("%s w%0d last", tag, i), lg[i].l, lmask[i]);
      if (consec) chk($sformatf("%s w%0d cycle", tag, i), lg[i].cyc - lg[0].cyc, i);
    end
  endtask

  task automatic push_both(input msg_t m0, input msg_t m1);
    lane[0].msgq.push_back(m0);
    lane[1].msgq.push_back(m1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #2;
    chk("rst in_ready L0", lane[0].bus.in_ready, 1);
    chk("rst in_ready L1", lane[1].bus.in_ready, 1);
    @(posedge clk);
    #2 reset = 1'b0;

    // Basic order, with and without header / reversed order.
    clear_logs();
    push_both('{32'h44332211, 3'd4}, '{32'hEE332211, 3'd3});
    wait_idle("t1");
    check_log(0, "t1 L0", '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0}, 4, 8'b0000_1000, 1'b1);
    check_log(1, "t1 L1", '{8'hA5, 8'h33, 8'h22, 8'h11, 0, 0, 0, 0}, 4, 8'b0000_1000, 1'b1);

    // Stalls with source data cleared after acceptance.
    rdy_mode = 2;
    zero_after = 1'b1;
    clear_logs();
    push_both('{32'h44332211, 3'd4}, '{32'h44332211, 3'd4});
    wait_idle("t2");
    check_log(0, "t2 L0", '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0}, 4, 8'b0000_1000, 1'b0);
    check_log(1, "t2 L1", '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 0, 0, 0}, 5, 8'b0001_0000, 1'b0);

    // Back-to-back messages.
    rdy_mode = 0;
    zero_after = 1'b0;
    clear_logs();
    push_both('{32'h00001211, 3'd2}, '{32'h00001211, 3'd2});
    push_both('{32'h88776655, 3'd4}, '{32'h88776655, 3'd4});
    wait_idle("t3");
    check_log(0, "t3 L0", '{8'h11, 8'h12, 8'h55, 8'h66, 8'h77, 8'h88, 0, 0}, 6, 8'b0010_0010, 1'b1);
    check_log(1, "t3 L1", '{8'hA5, 8'h12, 8'h11, 8'hA5, 8'h88, 8'h77, 8'h66, 8'h55}, 8,
              8'b1000_0100, 1'b1);

    // Zero length.
    clear_logs();
    push_both('{32'h12345678, 3'd0}, '{32'h12345678, 3'd0});
    wait_idle("t4");
    chk("t4 L0 words", lane[0].log.size(), 0);
    chk("t4 L0 len_err pulses", lane[0].err_pulses, 1);
    chk("t4 L0 busy cycles", lane[0].busy_cycles, 1);
    chk("t4 L1 len_err pulses", lane[1].err_pulses, 1);
    check_log(1, "t4 L1", '{8'hA5, 0, 0, 0, 0, 0, 0, 0}, 1, 8'b0000_0001, 1'b1);

    // Oversized length is clamped.
    clear_logs();
    push_both('{32'h44332211, 3'd7}, '{32'h44332211, 3'd7});
    wait_idle("t5");
    chk("t5 L0 len_err pulses", lane[0].err_pulses, 1);
    chk("t5 L1 len_err pulses", lane[1].err_pulses, 1);
    check_log(0, "t5 L0", '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0}, 4, 8'b0000_1000, 1'b1);
    check_log(1, "t5 L1", '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 0, 0, 0}, 5, 8'b0001_0000, 1'b1);

    // Asynchronous reset in the middle of a message.
    clear_logs();
    lane[0].msgq.push_back('{32'h44332211, 3'd4});
    n = 0;
    while (lane[0].log.size() < 2 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("t6 second word timeout", n >= 50, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("t6 async out_valid", lane[0].bus.out_valid, 0);
    chk("t6 async busy", lane[0].busy, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    clear_logs();
    lane[0].msgq.push_back('{32'hDDCCBBAA, 3'd4});
    wait_idle("t6");
    check_log(0, "t6 L0", '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 0, 0, 0, 0}, 4, 8'b0000_1000, 1'b1);

    // Random traffic against the model.
    rdy_mode = 1;
    clear_logs();
    for (int i = 0; i < 30; i++) begin
      push_both('{$urandom, 3'($urandom_range(0, 7))}, '{$urandom, 3'($urandom_range(0, 7))});
    end
    wait_idle("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
